// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state, coin codes and coin values.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 3'd1;
            COIN_2:  return 3'd2;
            COIN_5:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Idle-cycle timer for credit auto-refund; only built when VEND_TIMEOUT_EN is defined.
// o_expire pulses in the TIMEOUT_CYCLES-th consecutive running cycle since the last clear.
`ifdef VEND_TIMEOUT_EN
module vend_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != LP_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && !i_clear && (r_cnt == LP_LAST);

endmodule
`endif

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, purchase, dispense and unit-by-unit change return.
// Define VEND_TIMEOUT_EN to refund idle credit after TIMEOUT_CYCLES cycles.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE          = 4,
    parameter int MAX_CREDIT     = 9,
    parameter int CREDIT_W       = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_ready,
    output logic                coin_reject,
    output logic                disp_req,
    output logic                chg_req,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] LP_MAX   = CREDIT_W'(MAX_CREDIT);

    if ((MAX_CREDIT + 5 >= 2**CREDIT_W) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("vend_ctrl: illegal parameter combination");
    end

    vend_state_e         r_state;
    vend_state_e         w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_coin_reject;

    logic                w_ready;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_coin_try;
    logic                w_coin_acc;
    logic                w_coin_ovf;
    logic                w_timeout;

    assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    // MAX_CREDIT+5 fits in CREDIT_W, so the sum never wraps.
    assign w_sum      = r_credit + CREDIT_W'(coin_value(coin));
    assign w_coin_try = coin_valid && (coin != COIN_NONE) && w_ready;
    assign w_coin_acc = w_coin_try && (w_sum <= LP_MAX);
    assign w_coin_ovf = w_coin_try && !(w_sum <= LP_MAX);

`ifdef VEND_TIMEOUT_EN
    vend_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_coin_acc || (r_state != ST_CREDIT)),
        .i_run   (r_state == ST_CREDIT),
        .o_expire(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_coin_ovf;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = w_coin_acc ? w_sum : r_credit;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_acc) w_state_nxt = ST_CREDIT;
            end
            ST_CREDIT: begin
                // Price test uses the pre-add credit; a same-cycle coin still lands.
                if (cancel || w_timeout) begin
                    w_state_nxt = ST_CHANGE;
                end else if (sel && (r_credit >= LP_PRICE)) begin
                    w_state_nxt = ST_VEND;
                end
            end
            ST_VEND: begin
                if (disp_ack) begin
                    w_credit_nxt = r_credit - LP_PRICE;
                    w_state_nxt  = (r_credit == LP_PRICE) ? ST_IDLE : ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                if (r_credit == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (chg_ack) begin
                    w_credit_nxt = r_credit - 1'b1;
                    if (r_credit == CREDIT_W'(1)) w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_comb begin
        coin_ready = 1'b0;
        disp_req   = 1'b0;
        chg_req    = 1'b0;
        busy       = 1'b0;
        case (r_state)
            ST_IDLE, ST_CREDIT: coin_ready = 1'b1;
            ST_VEND: begin
                disp_req = 1'b1;
                busy     = 1'b1;
            end
            ST_CHANGE: begin
                chg_req = (r_credit != '0);
                busy    = 1'b1;
            end
            default: coin_ready = 1'b0;
        endcase
    end

    assign credit      = r_credit;
    assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random traffic against a
// credit/transaction reference model. Honours VEND_TIMEOUT_EN when defined.
module tb_vend_ctrl;

    localparam int PRICE          = 4;
    localparam int MAX_CREDIT     = 9;
    localparam int CREDIT_W       = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                coin_valid;
    logic [1:0]          coin;
    logic                sel;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                coin_ready;
    logic                coin_reject;
    logic                disp_req;
    logic                chg_req;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: credit held, plus whether a dispense or a refund is in progress.
    int m_credit = 0;
    bit m_vend   = 1'b0;
    bit m_refund = 1'b0;
    bit m_reject = 1'b0;
`ifdef VEND_TIMEOUT_EN
    int m_idle   = 0;
`endif

    vend_ctrl #(
        .PRICE         (PRICE),
        .MAX_CREDIT    (MAX_CREDIT),
        .CREDIT_W      (CREDIT_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coin_valid (coin_valid),
        .coin       (coin),
        .sel        (sel),
        .cancel     (cancel),
        .disp_ack   (disp_ack),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .coin_ready (coin_ready),
        .coin_reject(coin_reject),
        .disp_req   (disp_req),
        .chg_req    (chg_req),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit selling, in_credit, tried, fits, acc, to;
        int v, nc;
        if (reset) begin
            m_credit = 0; m_vend = 1'b0; m_refund = 1'b0; m_reject = 1'b0;
`ifdef VEND_TIMEOUT_EN
            m_idle = 0;
`endif
            return;
        end
        selling   = !m_vend && !m_refund;
        in_credit = selling && (m_credit > 0);
        v         = coin_units(coin);
        tried     = coin_valid && (coin != 2'b00) && selling;
        fits      = (m_credit + v) <= MAX_CREDIT;
        acc       = tried && fits;
        m_reject  = tried && !fits;
        nc        = m_credit + (acc ? v : 0);
        to        = 1'b0;
`ifdef VEND_TIMEOUT_EN
        if (in_credit && !acc) begin
            m_idle++;
            to = (m_idle == TIMEOUT_CYCLES);
        end else begin
            m_idle = 0;
        end
`endif
        if (selling) begin
            if (in_credit) begin
                if (cancel || to) m_refund = 1'b1;
                else if (sel && (m_credit >= PRICE)) m_vend = 1'b1;
            end
        end else if (m_vend) begin
            if (disp_ack) begin
                nc       = m_credit - PRICE;
                m_vend   = 1'b0;
                m_refund = (nc > 0);
            end
        end else if (chg_ack && (m_credit > 0)) begin
            nc = m_credit - 1;
            if (nc == 0) m_refund = 1'b0;
        end
        m_credit = nc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("credit",      credit,      m_credit);
        check_eq("coin_ready",  coin_ready,  !(m_vend || m_refund));
        check_eq("coin_reject", coin_reject, m_reject);
        check_eq("disp_req",    disp_req,    m_vend);
        check_eq("chg_req",     chg_req,     m_refund && (m_credit > 0));
        check_eq("busy",        busy,        m_vend || m_refund);
    endtask

    task automatic drive(input bit r, input bit cv, input logic [1:0] c, input bit s,
                         input bit cn, input bit da, input bit ca);
        reset = r; coin_valid = cv; coin = c; sel = s;
        cancel = cn; disp_ack = da; chg_ack = ca;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic put(input logic [1:0] c);
        drive(0, 1, c, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        check_eq("rst_credit", credit, 0);
        check_eq("rst_ready", coin_ready, 1);
        check_eq("rst_busy", busy, 0);

        // 2+2, buy exactly at price
        put(2'b10); put(2'b10);
        drive(0, 0, 2'b00, 1, 0, 0, 0);
        check_eq("s35_disp", disp_req, 1);
        drive(0, 0, 2'b00, 0, 0, 1, 0);
        check_eq("s35_credit", credit, 0);
        check_eq("s35_chg", chg_req, 0);
        check_eq("s35_busy", busy, 0);

        // 5+1, buy, two units of change
        put(2'b11); put(2'b01);
        drive(0, 0, 2'b00, 1, 0, 0, 0);
        drive(0, 0, 2'b00, 0, 0, 1, 0);
        check_eq("s36_chg", chg_req, 1);
        check_eq("s36_credit2", credit, 2);
        drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s36_credit1", credit, 1);
        drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s36_credit0", credit, 0);
        check_eq("s36_busy", busy, 0);

        // 5+2 then an overflowing 5
        put(2'b11); put(2'b10); put(2'b11);
        check_eq("s37_reject", coin_reject, 1);
        check_eq("s37_credit", credit, 7);
        idle();
        check_eq("s37_reject_clr", coin_reject, 0);
        drive(0, 0, 2'b00, 0, 1, 0, 0);
        repeat (7) drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s37_refunded", credit, 0);
        check_eq("s37_idle", busy, 0);

        // credit 3: sel ignored; cancel beats sel
        put(2'b10); put(2'b01);
        drive(0, 0, 2'b00, 1, 0, 0, 0);
        check_eq("s38_sel_ign", busy, 0);
        drive(0, 0, 2'b00, 1, 1, 0, 0);
        check_eq("s38_chg", chg_req, 1);
        check_eq("s38_no_disp", disp_req, 0);
        repeat (3) drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s38_credit", credit, 0);
        check_eq("s38_busy", busy, 0);

        // reset mid-vend with credit 6
        put(2'b11); put(2'b01);
        drive(0, 0, 2'b00, 1, 0, 0, 0);
        check_eq("s39_credit", credit, 6);
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        check_eq("s39_disp", disp_req, 0);
        check_eq("s39_credit0", credit, 0);
        check_eq("s39_ready", coin_ready, 1);

        // single unit left idle
        put(2'b01);
        repeat (TIMEOUT_CYCLES - 1) idle();
        check_eq("s40_pre", busy, 0);
        idle();
`ifdef VEND_TIMEOUT_EN
        check_eq("s40_timeout", chg_req, 1);
        drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s40_refund", credit, 0);
`else
        check_eq("s40_hold", busy, 0);
        repeat (2 * TIMEOUT_CYCLES) idle();
        check_eq("s40_hold_credit", credit, 1);
        drive(0, 0, 2'b00, 0, 1, 0, 0);
        drive(0, 0, 2'b00, 0, 0, 0, 1);
        check_eq("s40_refund", credit, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 4, meaning item price in credit units.
REQ-002 SHALL have parameter MAX_CREDIT, default 9, meaning maximum credit held.
REQ-003 SHALL have parameter CREDIT_W, default 4, meaning credit width, with MAX_CREDIT+5 < 2**CREDIT_W.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning idle cycles before auto-refund (macro only).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 coin_valid  in  1  coin present this cycle.
REQ-008 coin  in  2  coin code: 00 ignored, 01=1, 10=2, 11=5 units.
REQ-009 sel  in  1  purchase request pulse.
REQ-010 cancel  in  1  refund request pulse.
REQ-011 disp_ack  in  1  dispenser completes item.
REQ-012 chg_ack  in  1  changer returned one unit.
REQ-013 credit  out  CREDIT_W  current credit.
REQ-014 coin_ready  out  1  high in IDLE/CREDIT only.
REQ-015 coin_reject  out  1  one-cycle pulse, coin refused.
REQ-016 disp_req  out  1  dispense request, level.
REQ-017 chg_req  out  1  change request, level.
REQ-018 busy  out  1  high in VEND or CHANGE.

Function
REQ-019 SHALL implement states IDLE, CREDIT, VEND, CHANGE.
REQ-020 Coin accepted when coin_valid, coin!=00, coin_ready, and credit+value <= MAX_CREDIT; credit updates next cycle; IDLE->CREDIT.
REQ-021 Coin with coin_valid, coin_ready, and overflow SHALL not change credit and SHALL pulse coin_reject next cycle.
REQ-022 Coins while coin_ready low SHALL be ignored without coin_reject.
REQ-023 CREDIT: sel with credit (pre-add value this cycle) >= PRICE -> VEND; otherwise sel ignored.
REQ-024 cancel in CREDIT -> CHANGE; cancel beats sel same cycle; a coin in that cycle is still added and refunded.
REQ-025 disp_req SHALL assert the cycle after VEND entry and hold until disp_ack is sampled high; disp_ack outside VEND ignored.
REQ-026 On disp_ack: credit <= credit-PRICE; next state CHANGE if result >0, else IDLE.
REQ-027 CHANGE: chg_req high while credit>0; each cycle with chg_req&chg_ack decrements credit by 1; at 0 -> IDLE, chg_req low same edge.
REQ-028 sel/cancel in IDLE, VEND, CHANGE SHALL be ignored.

Reset
REQ-029 reset SHALL force IDLE, credit=0, disp_req=0, chg_req=0, coin_reject=0, busy=0, coin_ready=1 next cycle.
REQ-030 Reset mid-VEND/CHANGE SHALL abandon the transaction and discard credit.

Configuration
REQ-031 With VEND_TIMEOUT_EN defined: counter clears on IDLE->CREDIT and on each accepted coin; reaching TIMEOUT_CYCLES in CREDIT forces CHANGE (full refund).
REQ-032 Without VEND_TIMEOUT_EN: no counter; CREDIT held indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum, coin code constants, and coin-value function.
REQ-034 Sub-module vend_timer (load/clear, expire pulse) SHALL be instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-035 Coins 2,2 then sel -> disp_req next cycle; disp_ack -> credit 0, IDLE, no chg_req.
REQ-036 Coins 5,1, sel, disp_ack -> CHANGE, two chg_ack handshakes, credit 2->1->0, IDLE.
REQ-037 Coins 5,2 then 5 -> third coin_reject pulse, credit stays 7.
REQ-038 Credit 3, sel -> ignored; cancel+sel same cycle at credit 3 -> CHANGE, three units returned.
REQ-039 Reset during VEND with credit 6 -> disp_req low, credit 0, IDLE next cycle.
REQ-040 VEND_TIMEOUT_EN, coin 1 then 16 idle cycles -> CHANGE, one unit refunded.
